data_cache_refill_unit: RTL and testbench
=========================================

Name: data_cache_refill_unit

Overview:
- Miss handler directly downstream of the L1 data cache's miss indication and upstream of its 128-bit line-fill input.
- On an L1 miss it fetches the 4-word line from word-wide main data memory, one word per handshake.
- It assembles the words into a 128-bit line and presents the line with its line-aligned address for a one-cycle fill pulse.
- The fill address is explicit, so the cache writes the correct index/tag directly and does not reconstruct it from the CPU address.

Parameters:
- ADDR_W, 32, byte address width.
- WORDS_PER_LINE, 4, 32-bit words per cache line (fixed at 4 for L1; line = 128 bits).
- OFFSET_W, 4, byte-offset bits within a line (log2(WORDS_PER_LINE*4)).

Ports:
- Clk  input  1  system clock; all state changes on posedge.
- Reset_n  input  1  asynchronous, active-low reset.
- miss_req  input  1  L1 reports a miss (hit==0 with readMem or writeMem); level, may stay high across cycles while the CPU replays.
- miss_addr  input  ADDR_W  CPU byte address of the missing access.
- busy  output  1  refill in progress (any state other than IDLE).
- mem_req  output  1  word read request to main memory.
- mem_addr  output  ADDR_W  word address of the current beat; stable while mem_req is high and not acknowledged.
- mem_ack  input  1  main memory returns mem_rdata this cycle.
- mem_rdata  input  32  returned word.
- fill_valid  output  1  one-cycle pulse; L1 must write fill_line at fill_addr.
- fill_line  output  128  assembled line; word k occupies bits [32k+31:32k], matching offset address[3:2]==k.
- fill_addr  output  ADDR_W  line-aligned address (miss_addr with bits [3:0] cleared).

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE, busy=0, mem_req=0, mem_addr=0, fill_valid=0, fill_line=0, fill_addr=0, beat counter=0, last_line_valid=0.
- States: IDLE, FETCH, FILL, GUARD.
- IDLE, miss_req=1 and not suppressed:
  - latch base = {miss_addr[31:4],4'b0} into fill_addr; beat=0;
  - next state FETCH;
  - mem_req=1 and mem_addr=base from the next cycle.
- FETCH:
  - mem_req held high continuously.
  - mem_addr = base + 4*beat.
  - On a mem_ack cycle, capture mem_rdata into word slot beat.
  - If beat==3 on that ack: go to FILL, drop mem_req next cycle. Otherwise beat+1, and mem_addr advances the next cycle.
  - No ack means wait indefinitely; there is no timeout.
  - Beat counter is 2 bits; it never wraps past 3 inside a refill.
- FILL: fill_valid=1 for exactly one cycle with fill_line/fill_addr stable; record last_line = fill_addr[31:4], last_line_valid=1; next state GUARD.
- GUARD: one idle cycle, so the L1 registered hit can update. Next state IDLE.
- Suppression: in IDLE, a miss_req whose miss_addr[31:4]==last_line while last_line_valid is ignored for the first IDLE cycle after GUARD only. A differing line is accepted immediately.
- miss_req while busy is ignored. The CPU replays, so the miss is re-presented later. miss_addr changes mid-refill do not affect the latched base.
- Latency, zero-wait memory (ack in the same cycle as req):
  - miss_req sampled at cycle 0, first mem_req at cycle 1;
  - acks at cycles 1-4, fill_valid at cycle 5, GUARD at cycle 6, IDLE at cycle 7.
- fill_line contents persist until the next refill's first capture. Slots are overwritten individually.
- Reset mid-refill: immediate abort to reset values; no fill_valid is produced; the partial line is discarded.
- mem_ack while not in FETCH is ignored.
- Address arithmetic is modulo 2^ADDR_W. The base is line-aligned, so beat addresses never cross a line.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, FETCH=2'd1, FILL=2'd2, GUARD=2'd3);
  - LINE_W=128, WORD_W=32, OFFSET_W=4;
  - the line-base masking function used by both L1 and this unit.
- One natural sub-module, refill_line_assembler: beat counter plus 4x32 word slot register with a write-enable per slot. The FSM stays in the top.

Test Plan:
- Reset then miss_req=1, miss_addr=0x0000_0124, zero-wait memory returning 0x11,0x22,0x33,0x44 -> mem_addr 0x120,0x124,0x128,0x12C on cycles 1-4; fill_valid at cycle 5 with fill_line=0x00000044_00000033_00000022_00000011, fill_addr=0x120.
- Same miss with mem_ack delayed 3 cycles per beat -> mem_addr and mem_req stable during waits; fill_valid only after the 4th ack; one pulse only.
- miss_req held high through the refill and after, for the same line 0x120 -> exactly one refill; no second mem_req in the IDLE cycle after GUARD.
- Immediately after the fill of 0x120, miss_req for 0x0000_0A40 -> new refill starts in the first IDLE cycle; mem_addr=0xA40.
- Reset_n low after the 2nd ack of a refill -> all outputs 0 immediately; no fill_valid. The next miss starts at beat 0.
- mem_ack pulsed while IDLE, and miss_addr changed mid-FETCH -> no captures, fill_addr unchanged, fill_line reflects only the FETCH-state acks.

Source files
------------

// File: rtl/data_cache_refill_unit_pkg.sv
// Shared definitions for the L1 data cache refill path: state encoding,
// line/word geometry and the line-base masking helper used by L1 and the
// refill unit alike.
package data_cache_refill_unit_pkg;

  localparam int LINE_W     = 128;
  localparam int WORD_W     = 32;
  localparam int OFFSET_W   = 4;
  localparam int PKG_ADDR_W = 32;

  // Refill FSM encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  // Clear the byte offset within a line so the result is line aligned
  function automatic logic [PKG_ADDR_W-1:0] line_base(input logic [PKG_ADDR_W-1:0] addr);
    line_base = {addr[PKG_ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/data_cache_refill_unit_refill_line_assembler.sv
// Beat counter plus the four word slots that build up a cache line.
// Each slot has its own write enable, so a slot only changes when its own
// beat is captured; the line therefore persists between refills.
module refill_line_assembler #(
  parameter int WORDS = 4,
  parameter int WW    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  capture,
  input  logic [WW-1:0]         wdata,
  output logic [1:0]            beat,
  output logic [WORDS*WW-1:0]   line
);

  logic [1:0]          beat_d;
  logic [1:0]          beat_q;
  logic [WORDS*WW-1:0] line_d;
  logic [WORDS*WW-1:0] line_q;
  logic [WORDS-1:0]    slot_we_s;

  assign beat = beat_q;
  assign line = line_q;

  // Next beat index and per-slot write of the returned word
  always_comb begin
    beat_d    = beat_q;
    line_d    = line_q;
    slot_we_s = '0;
    if (start) begin
      beat_d = 2'd0;
    end else if (capture) begin
      beat_d = beat_q + 2'd1;
    end else begin
      beat_d = beat_q;
    end
    for (int k = 0; k < WORDS; k++) begin
      slot_we_s[k] = capture && !start && (beat_q == 2'(k));
      if (slot_we_s[k]) begin
        line_d[k*WW +: WW] = wdata;
      end else begin
        line_d[k*WW +: WW] = line_q[k*WW +: WW];
      end
    end
  end

  // Beat counter and slot storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= 2'd0;
      line_q <= '0;
    end else begin
      beat_q <= beat_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/data_cache_refill_unit.sv
// L1 data cache miss handler: fetches a four-word line one word per
// handshake, then presents the assembled line and its aligned address for
// a single-cycle fill. A GUARD cycle lets the L1 hit register settle, and
// the first IDLE cycle afterwards ignores a replayed miss to the same line.
module data_cache_refill_unit #(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int OFFSET_W       = 4
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         miss_req,
  input  logic [ADDR_W-1:0]            miss_addr,
  output logic                         busy,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  input  logic [31:0]                  mem_rdata,
  output logic                         fill_valid,
  output logic [WORDS_PER_LINE*32-1:0] fill_line,
  output logic [ADDR_W-1:0]            fill_addr
);

  import data_cache_refill_unit_pkg::*;

  logic [1:0]               state_d;
  logic [1:0]               state_q;
  logic                     busy_d;
  logic                     busy_q;
  logic                     mem_req_d;
  logic                     mem_req_q;
  logic [ADDR_W-1:0]        mem_addr_d;
  logic [ADDR_W-1:0]        mem_addr_q;
  logic                     fill_valid_d;
  logic                     fill_valid_q;
  logic [ADDR_W-1:0]        fill_addr_d;
  logic [ADDR_W-1:0]        fill_addr_q;
  logic [ADDR_W-OFFSET_W-1:0] last_line_d;
  logic [ADDR_W-OFFSET_W-1:0] last_line_q;
  logic                     last_line_valid_d;
  logic                     last_line_valid_q;
  logic                     suppress_d;
  logic                     suppress_q;

  logic                     start_s;
  logic                     capture_s;
  logic                     suppressed_s;
  logic [ADDR_W-1:0]        base_s;
  logic [1:0]               beat_s;

  assign busy       = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign fill_valid = fill_valid_q;
  assign fill_addr  = fill_addr_q;

  refill_line_assembler #(
    .WORDS (WORDS_PER_LINE),
    .WW    (32)
  ) u_assembler (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .start   (start_s),
    .capture (capture_s),
    .wdata   (mem_rdata),
    .beat    (beat_s),
    .line    (fill_line)
  );

  // Refill sequencing: accept a miss, walk four beats, pulse fill, guard
  always_comb begin
    state_d           = state_q;
    mem_req_d         = mem_req_q;
    mem_addr_d        = mem_addr_q;
    fill_valid_d      = 1'b0;
    fill_addr_d       = fill_addr_q;
    last_line_d       = last_line_q;
    last_line_valid_d = last_line_valid_q;
    suppress_d        = 1'b0;
    start_s           = 1'b0;
    capture_s         = 1'b0;
    base_s            = line_base(miss_addr);
    suppressed_s      = suppress_q && last_line_valid_q &&
                        (miss_addr[ADDR_W-1:OFFSET_W] == last_line_q);
    case (state_q)
      ST_IDLE: begin
        if (miss_req && !suppressed_s) begin
          state_d     = ST_FETCH;
          start_s     = 1'b1;
          mem_req_d   = 1'b1;
          mem_addr_d  = base_s;
          fill_addr_d = base_s;
        end else begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      ST_FETCH: begin
        mem_req_d = 1'b1;
        if (mem_ack) begin
          capture_s = 1'b1;
          if (beat_s == 2'd3) begin
            state_d      = ST_FILL;
            mem_req_d    = 1'b0;
            fill_valid_d = 1'b1;
          end else begin
            // Base is line aligned, so the beat step never leaves the line
            mem_addr_d = mem_addr_q + {{(ADDR_W-3){1'b0}}, 3'b100};
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FILL: begin
        last_line_d       = fill_addr_q[ADDR_W-1:OFFSET_W];
        last_line_valid_d = 1'b1;
        state_d           = ST_GUARD;
      end
      ST_GUARD: begin
        // Arms same-line suppression for exactly the next IDLE cycle
        suppress_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers, cleared immediately by reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q           <= ST_IDLE;
      busy_q            <= 1'b0;
      mem_req_q         <= 1'b0;
      mem_addr_q        <= '0;
      fill_valid_q      <= 1'b0;
      fill_addr_q       <= '0;
      last_line_q       <= '0;
      last_line_valid_q <= 1'b0;
      suppress_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      busy_q            <= busy_d;
      mem_req_q         <= mem_req_d;
      mem_addr_q        <= mem_addr_d;
      fill_valid_q      <= fill_valid_d;
      fill_addr_q       <= fill_addr_d;
      last_line_q       <= last_line_d;
      last_line_valid_q <= last_line_valid_d;
      suppress_q        <= suppress_d;
    end
  end

endmodule

// File: tb/tb_data_cache_refill_unit.sv
// Self-checking bench for data_cache_refill_unit: a directed table for the
// zero-wait refill, hand sequences for the multi-cycle corner cases, and a
// randomized run against a transaction-level reference model.
module tb_data_cache_refill_unit;

  logic         Clk;
  logic         Reset_n;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         busy;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         fill_valid;
  logic [127:0] fill_line;
  logic [31:0]  fill_addr;

  int passed;
  int total;

  data_cache_refill_unit dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .fill_valid (fill_valid),
    .fill_line  (fill_line),
    .fill_addr  (fill_addr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic         miss;
    logic [31:0]  addr;
    logic         ack;
    logic [31:0]  rdata;
    logic         busy;
    logic         req;
    logic [31:0]  maddr;
    logic         fv;
    logic [31:0]  faddr;
    logic [127:0] line;
  } vec_t;

  vec_t vecs[8];

  // Reference model state (transaction level)
  bit          m_active;
  int          m_got;
  int          m_post;
  logic [31:0] m_base;
  logic [31:0] m_fill_addr;
  logic [31:0] m_line[4];
  logic [27:0] m_last_line;
  bit          m_last_valid;
  bit          m_first_idle;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Advance one clock: outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n   = 1'b0;
    miss_req  = 1'b0;
    miss_addr = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    cyc();
    cyc();
    Reset_n = 1'b1;
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_got = 0; m_post = 0; m_base = 32'h0; m_fill_addr = 32'h0;
    for (int i = 0; i < 4; i++) m_line[i] = 32'h0;
    m_last_line = 28'h0; m_last_valid = 1'b0; m_first_idle = 1'b0;
  endtask

  // Advance the model across one clock edge using the sampled inputs
  task automatic model_step();
    if (!m_active) begin
      if (miss_req && !(m_first_idle && m_last_valid && (miss_addr[31:4] == m_last_line))) begin
        m_active    = 1'b1;
        m_base      = miss_addr & 32'hFFFF_FFF0;
        m_fill_addr = m_base;
        m_got       = 0;
        m_post      = 0;
      end
      m_first_idle = 1'b0;
    end else if (m_got < 4) begin
      if (mem_ack) begin
        m_line[m_got] = mem_rdata;
        m_got++;
        if (m_got == 4) m_post = 1;
      end
    end else begin
      m_post++;
      if (m_post == 2) begin
        m_last_line  = m_base[31:4];
        m_last_valid = 1'b1;
      end
      if (m_post == 3) begin
        m_active     = 1'b0;
        m_first_idle = 1'b1;
      end
    end
  endtask

  task automatic model_check();
    logic exp_req;
    exp_req = m_active && (m_got < 4);
    chk("rnd_busy", 128'(busy), 128'(m_active));
    chk("rnd_mem_req", 128'(mem_req), 128'(exp_req));
    if (exp_req) chk("rnd_mem_addr", 128'(mem_addr), 128'(m_base + 32'(4 * m_got)));
    chk("rnd_fill_valid", 128'(fill_valid), 128'(m_active && (m_post == 1)));
    chk("rnd_fill_addr", 128'(fill_addr), 128'(m_fill_addr));
    chk("rnd_fill_line", fill_line, {m_line[3], m_line[2], m_line[1], m_line[0]});
  endtask

  initial begin
    int fills;
    int reqs;
    logic [31:0] lines[4];
    passed = 0;
    total  = 0;

    // ---------------- Directed zero-wait refill table ----------------
    vecs[0] = '{1'b1, 32'h124, 1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000, 128'h0};
    vecs[1] = '{1'b1, 32'h124, 1'b1, 32'h11, 1'b1, 1'b1, 32'h120, 1'b0, 32'h120, 128'h0};
    vecs[2] = '{1'b1, 32'h124, 1'b1, 32'h22, 1'b1, 1'b1, 32'h124, 1'b0, 32'h120, 128'h11};
    vecs[3] = '{1'b1, 32'h124, 1'b1, 32'h33, 1'b1, 1'b1, 32'h128, 1'b0, 32'h120, 128'h00000022_00000011};
    vecs[4] = '{1'b1, 32'h124, 1'b1, 32'h44, 1'b1, 1'b1, 32'h12C, 1'b0, 32'h120, 128'h00000033_00000022_00000011};
    vecs[5] = '{1'b0, 32'h124, 1'b0, 32'h00, 1'b1, 1'b0, 32'h000, 1'b1, 32'h120, 128'h00000044_00000033_00000022_00000011};
    vecs[6] = '{1'b0, 32'h124, 1'b0, 32'h00, 1'b1, 1'b0, 32'h000, 1'b0, 32'h120, 128'h00000044_00000033_00000022_00000011};
    vecs[7] = '{1'b0, 32'h124, 1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 1'b0, 32'h120, 128'h00000044_00000033_00000022_00000011};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      miss_req  = vecs[i].miss;
      miss_addr = vecs[i].addr;
      mem_ack   = vecs[i].ack;
      mem_rdata = vecs[i].rdata;
      chk($sformatf("tbl%0d_busy", i), 128'(busy), 128'(vecs[i].busy));
      chk($sformatf("tbl%0d_mem_req", i), 128'(mem_req), 128'(vecs[i].req));
      if (vecs[i].req || i == 0) chk($sformatf("tbl%0d_mem_addr", i), 128'(mem_addr), 128'(vecs[i].maddr));
      chk($sformatf("tbl%0d_fill_valid", i), 128'(fill_valid), 128'(vecs[i].fv));
      chk($sformatf("tbl%0d_fill_addr", i), 128'(fill_addr), 128'(vecs[i].faddr));
      chk($sformatf("tbl%0d_fill_line", i), fill_line, vecs[i].line);
      cyc();
    end

    // ---------------- Three wait cycles per beat ----------------
    do_reset();
    miss_req = 1'b1; miss_addr = 32'h124;
    cyc();
    miss_req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 3; w++) begin
        mem_ack = 1'b0;
        chk("wait_mem_req", 128'(mem_req), 128'd1);
        chk("wait_mem_addr", 128'(mem_addr), 128'(32'h120 + 32'(4 * b)));
        chk("wait_fill_valid", 128'(fill_valid), 128'd0);
        cyc();
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'h11 * 32'(b + 1);
      chk("ack_mem_addr", 128'(mem_addr), 128'(32'h120 + 32'(4 * b)));
      cyc();
    end
    mem_ack = 1'b0;
    chk("wait_fill_pulse", 128'(fill_valid), 128'd1);
    chk("wait_fill_line", fill_line, 128'h00000044_00000033_00000022_00000011);
    chk("wait_fill_addr", 128'(fill_addr), 128'h120);
    fills = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (fill_valid) fills++;
    end
    chk("wait_single_pulse", 128'(fills), 128'd0);

    // ---------------- miss_req held for the same line ----------------
    do_reset();
    miss_req = 1'b1; miss_addr = 32'h124; mem_ack = 1'b1;
    fills = 0; reqs = 0;
    for (int c = 0; c <= 12; c++) begin
      if (c == 8) miss_req = 1'b0;
      mem_rdata = 32'h11 * 32'(c);
      if (mem_req) reqs++;
      if (fill_valid) fills++;
      if (c == 7) chk("held_idle_busy", 128'(busy), 128'd0);
      if (c == 8) chk("held_suppressed_req", 128'(mem_req), 128'd0);
      cyc();
    end
    mem_ack = 1'b0;
    chk("held_fill_count", 128'(fills), 128'd1);
    chk("held_req_cycles", 128'(reqs), 128'd4);

    // ---------------- Different line accepted in first IDLE cycle ----------------
    do_reset();
    miss_req = 1'b1; miss_addr = 32'h124;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) miss_req = 1'b0;
      mem_ack   = (c >= 1 && c <= 4);
      mem_rdata = 32'h100 + 32'(c);
      if (c == 7) begin
        miss_req = 1'b1; miss_addr = 32'h0000_0A40;
        chk("newline_idle", 128'(busy), 128'd0);
      end
      cyc();
    end
    miss_req = 1'b0; mem_ack = 1'b0;
    chk("newline_mem_req", 128'(mem_req), 128'd1);
    chk("newline_mem_addr", 128'(mem_addr), 128'hA40);
    chk("newline_fill_addr", 128'(fill_addr), 128'hA40);

    // ---------------- Reset after the second ack ----------------
    do_reset();
    miss_req = 1'b1; miss_addr = 32'h124;
    cyc();
    miss_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hAA;
    cyc();
    mem_rdata = 32'hBB;
    cyc();
    mem_ack = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_mem_req", 128'(mem_req), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_fill_valid", 128'(fill_valid), 128'd0);
    chk("rst_fill_line", fill_line, 128'd0);
    chk("rst_fill_addr", 128'(fill_addr), 128'd0);
    cyc();
    Reset_n = 1'b1;
    fills = 0;
    for (int c = 0; c < 6; c++) begin
      if (fill_valid || busy) fills++;
      cyc();
    end
    chk("rst_no_fill", 128'(fills), 128'd0);
    miss_req = 1'b1; miss_addr = 32'h208;
    cyc();
    miss_req = 1'b0; mem_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      mem_rdata = 32'(b + 1);
      cyc();
    end
    mem_ack = 1'b0;
    chk("rst_next_fill_valid", 128'(fill_valid), 128'd1);
    chk("rst_next_fill_line", fill_line, 128'h00000004_00000003_00000002_00000001);
    chk("rst_next_fill_addr", 128'(fill_addr), 128'h200);

    // ---------------- Idle acks ignored, miss_addr change mid-FETCH ----------------
    do_reset();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    cyc();
    mem_rdata = 32'hCAFE_F00D;
    cyc();
    chk("idle_ack_line", fill_line, 128'd0);
    chk("idle_ack_busy", 128'(busy), 128'd0);
    mem_ack = 1'b0; miss_req = 1'b1; miss_addr = 32'h308;
    cyc();
    miss_req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_ack = 1'b0;
      if (b == 1) begin
        miss_req = 1'b1; miss_addr = 32'h5000;
      end
      cyc();
      mem_ack   = 1'b1;
      mem_rdata = 32'hA0 + 32'(b);
      chk("midchg_mem_addr", 128'(mem_addr), 128'(32'h300 + 32'(4 * b)));
      cyc();
    end
    mem_ack = 1'b0; miss_req = 1'b0;
    chk("midchg_fill_valid", 128'(fill_valid), 128'd1);
    chk("midchg_fill_addr", 128'(fill_addr), 128'h300);
    chk("midchg_fill_line", fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
    for (int c = 0; c < 3; c++) cyc();

    // ---------------- Randomized run against the reference model ----------------
    lines[0] = 32'h0000_0120;
    lines[1] = 32'h0000_0A40;
    lines[2] = 32'hFFFF_FFF0;
    lines[3] = 32'h0000_0000;
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      miss_req  = ($urandom_range(0, 2) != 0);
      miss_addr = lines[$urandom_range(0, 3)] | 32'($urandom_range(0, 15));
      mem_ack   = ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      model_check();
      cyc();
      model_step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
